// File: rtl/upower_pkg.sv
// rtl/upower_pkg.sv - shared store opcodes, store-buffer entry layout and drain FSM encoding
package upower_pkg;

    localparam logic [5:0] PO_STB = 6'd38;
    localparam logic [5:0] PO_STH = 6'd44;
    localparam logic [5:0] PO_STW = 6'd36;
    localparam logic [5:0] PO_STD = 6'd62;

    localparam int DW_W    = 61;
    localparam int ENTRY_W = DW_W + 64 + 8;

    typedef struct packed {
        logic [DW_W-1:0] dw;
        logic [63:0]     wdata;
        logic [7:0]      be;
    } sb_entry_t;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_ISSUE = 1'b1
    } drain_state_t;

endpackage

// File: rtl/store_buffer_fifo.sv
// rtl/store_buffer_fifo.sv - DEPTH-entry synchronous FIFO of store entries with per-slot valid bits
module store_buffer_fifo
    import upower_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  sb_entry_t                      push_entry,
    input  logic                           pop,
    output sb_entry_t                      head,
    output logic                           full,
    output logic                           empty,
    output logic [CW-1:0]                  count,
    output logic [DEPTH-1:0]               vld,
    output logic [DEPTH-1:0][DW_W-1:0]     dw
);

    sb_entry_t         mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr;
    logic [PW-1:0]     rd_ptr;
    logic [CW-1:0]     count_q;
    logic [DEPTH-1:0]  vld_q;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;
    assign vld     = vld_q;
    assign head    = mem_q[rd_ptr];

    // Pointers, occupancy and slot-valid bits; pointers wrap naturally since DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
            vld_q   <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr        <= wr_ptr + PW'(1);
                vld_q[wr_ptr] <= 1'b1;
            end
            if (pop_ok) begin
                rd_ptr        <= rd_ptr + PW'(1);
                vld_q[rd_ptr] <= 1'b0;
            end
            count_q <= count_q + CW'(push_ok) - CW'(pop_ok);
        end
    end

    // Entry storage; contents are qualified by vld_q so they need no reset
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr] <= push_entry;
        end
    end

    // Expose every slot's doubleword address for the load-overlap compare
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            dw[i] = mem_q[i].dw;
        end
    end

endmodule

// File: rtl/store_buffer_unit.sv
// rtl/store_buffer_unit.sv - store sizing/lane alignment, FIFO queue and memory drain; STORE_FWD_EN enables load-overlap check
module store_buffer_unit
    import upower_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         st_valid,
    output logic                         st_ready,
    input  logic [5:0]                   st_po,
    input  logic [63:0]                  st_addr,
    input  logic [63:0]                  st_data,
    output logic                         st_err,
    output logic                         mem_valid,
    input  logic                         mem_ready,
    output logic [63:0]                  mem_addr,
    output logic [63:0]                  mem_wdata,
    output logic [7:0]                   mem_be,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         empty,
    input  logic [63:0]                  ld_chk_addr,
    output logic                         ld_chk_hit
);

    localparam int CW = $clog2(DEPTH + 1);

    logic                        accept;
    logic                        aligned_ok;
    logic [2:0]                  off;
    logic [63:0]                 sized;
    logic [7:0]                  be_base;
    logic [63:0]                 lane_data;
    logic [7:0]                  lane_be;
    logic                        push;
    logic                        pop;
    sb_entry_t                   new_entry;
    sb_entry_t                   head;
    logic                        fifo_full;
    logic                        fifo_empty;
    logic [CW-1:0]               fifo_count;
    logic [DEPTH-1:0]            fifo_vld;
    logic [DEPTH-1:0][DW_W-1:0]  fifo_dw;
    drain_state_t                state_q;
    drain_state_t                state_d;

    // Full is derived from the registered count, so a pop never frees a slot in the same cycle
    assign st_ready = !rst && !fifo_full;
    assign accept   = st_valid && st_ready;
    assign off      = st_addr[2:0];

    // Size the store by opcode and check the offset is naturally aligned for that size
    always_comb begin
        sized      = '0;
        be_base    = '0;
        aligned_ok = 1'b0;
        case (st_po)
            PO_STB: begin
                sized      = {56'b0, st_data[7:0]};
                be_base    = 8'h01;
                aligned_ok = 1'b1;
            end
            PO_STH: begin
                sized      = {48'b0, st_data[15:0]};
                be_base    = 8'h03;
                aligned_ok = (off[0] == 1'b0);
            end
            PO_STW: begin
                sized      = {32'b0, st_data[31:0]};
                be_base    = 8'h0F;
                aligned_ok = (off[1:0] == 2'b00);
            end
            PO_STD: begin
                sized      = st_data;
                be_base    = 8'hFF;
                aligned_ok = (off == 3'b000);
            end
            default: begin
                sized      = '0;
                be_base    = '0;
                aligned_ok = 1'b0;
            end
        endcase
    end

    // Little-endian lane placement: the low byte of the sized data lands in lane off
    assign lane_data = sized << {off, 3'b000};
    assign lane_be   = be_base << off;

    assign push            = accept && aligned_ok;
    assign new_entry.dw    = st_addr[63:3];
    assign new_entry.wdata = lane_data;
    assign new_entry.be    = lane_be;

    // Rejected requests still consume the handshake; flag them one cycle later
    always_ff @(posedge clk) begin
        if (rst) begin
            st_err <= 1'b0;
        end else begin
            st_err <= accept && !aligned_ok;
        end
    end

    store_buffer_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (new_entry),
        .pop        (pop),
        .head       (head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count),
        .vld        (fifo_vld),
        .dw         (fifo_dw)
    );

    assign count = fifo_count;
    assign empty = fifo_empty;

    // Drain FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Drain FSM: present the head entry and pop on mem_ready; leave ISSUE only when the last entry goes
    always_comb begin
        state_d   = state_q;
        mem_valid = 1'b0;
        pop       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                mem_valid = 1'b1;
                if (mem_ready) begin
                    pop = 1'b1;
                    if (!(fifo_count > CW'(1)) && !push) begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Memory payload is zero when nothing is presented; head is stable while stalled
    assign mem_addr  = mem_valid ? {head.dw, 3'b000} : 64'd0;
    assign mem_wdata = mem_valid ? head.wdata : 64'd0;
    assign mem_be    = mem_valid ? head.be : 8'd0;

`ifdef STORE_FWD_EN
    logic unused_bits;
    assign unused_bits = ^ld_chk_addr[2:0];

    // Doubleword-granular overlap of the load address with any pending store
    always_comb begin
        ld_chk_hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (fifo_vld[i] && (fifo_dw[i] == ld_chk_addr[63:3])) begin
                ld_chk_hit = 1'b1;
            end
        end
    end
`else
    logic unused_bits;
    assign unused_bits = ^{ld_chk_addr, fifo_vld, fifo_dw};
    assign ld_chk_hit  = 1'b0;
`endif

endmodule

// File: tb/tb_store_buffer_unit.sv
// tb/tb_store_buffer_unit.sv - directed self-checking bench for store_buffer_unit
module tb_store_buffer_unit;

`ifdef STORE_FWD_EN
    localparam logic FWD = 1'b1;
`else
    localparam logic FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        st_valid;
    logic        st_ready;
    logic [5:0]  st_po;
    logic [63:0] st_addr;
    logic [63:0] st_data;
    logic        st_err;
    logic        mem_valid;
    logic        mem_ready;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_be;
    logic [2:0]  count;
    logic        empty;
    logic [63:0] ld_chk_addr;
    logic        ld_chk_hit;

    int vectors = 0;
    int miscompares = 0;

    store_buffer_unit #(.DEPTH(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .st_valid    (st_valid),
        .st_ready    (st_ready),
        .st_po       (st_po),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_err      (st_err),
        .mem_valid   (mem_valid),
        .mem_ready   (mem_ready),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_be      (mem_be),
        .count       (count),
        .empty       (empty),
        .ld_chk_addr (ld_chk_addr),
        .ld_chk_hit  (ld_chk_hit)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int n;
        n = 0;
        while (!mem_valid && n < 10) begin
            step();
            n++;
        end
        chk(tag, {63'd0, mem_valid}, 64'd1);
    endtask

    task automatic drive(input logic [5:0] po, input logic [63:0] addr, input logic [63:0] data);
        st_valid = 1'b1;
        st_po    = po;
        st_addr  = addr;
        st_data  = data;
    endtask

    initial begin
        rst = 1'b1; st_valid = 1'b0; st_po = '0; st_addr = '0; st_data = '0;
        mem_ready = 1'b0; ld_chk_addr = '0;
        step(); step();
        chk("rst_st_ready", {63'd0, st_ready}, 64'd0);
        rst = 1'b0;
        step();
        chk("rst_st_ready_after", {63'd0, st_ready}, 64'd1);
        chk("rst_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rst_mem_addr", mem_addr, 64'd0);
        chk("rst_mem_wdata", mem_wdata, 64'd0);
        chk("rst_mem_be", {56'd0, mem_be}, 64'd0);
        chk("rst_count", {61'd0, count}, 64'd0);
        chk("rst_empty", {63'd0, empty}, 64'd1);
        chk("rst_st_err", {63'd0, st_err}, 64'd0);
        chk("rst_hit", {63'd0, ld_chk_hit}, 64'd0);

        // stb at byte offset 3
        mem_ready = 1'b1;
        drive(6'd38, 64'h1003, 64'hFFFF_FFFF_FFFF_FFAB);
        step();
        st_valid = 1'b0;
        wait_valid("stb_valid_timeout");
        chk("stb_addr", mem_addr, 64'h1000);
        chk("stb_be", {56'd0, mem_be}, 64'h08);
        chk("stb_wdata", mem_wdata, 64'h0000_0000_AB00_0000);
        step();
        chk("stb_empty", {63'd0, empty}, 64'd1);
        chk("stb_mem_valid_off", {63'd0, mem_valid}, 64'd0);

        // misaligned sth is rejected
        drive(6'd44, 64'h2005, 64'h1234);
        step();
        st_valid = 1'b0;
        chk("sth_mis_err", {63'd0, st_err}, 64'd1);
        chk("sth_mis_count", {61'd0, count}, 64'd0);
        step();
        chk("sth_mis_err_clear", {63'd0, st_err}, 64'd0);
        chk("sth_mis_count2", {61'd0, count}, 64'd0);

        // unknown opcode is rejected
        drive(6'd1, 64'h2000, 64'h1);
        step();
        st_valid = 1'b0;
        chk("bad_po_err", {63'd0, st_err}, 64'd1);
        chk("bad_po_count", {61'd0, count}, 64'd0);

        // aligned sth at offset 6, upper data bits must be masked
        mem_ready = 1'b0;
        drive(6'd44, 64'h2006, 64'hFFFF_FFFF_FFFF_1234);
        step();
        st_valid = 1'b0;
        wait_valid("sth_valid_timeout");
        chk("sth_addr", mem_addr, 64'h2000);
        chk("sth_be", {56'd0, mem_be}, 64'hC0);
        chk("sth_wdata", mem_wdata, 64'h1234_0000_0000_0000);
        chk("sth_err", {63'd0, st_err}, 64'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        chk("sth_drained", {61'd0, count}, 64'd0);

        // five back-to-back std with memory stalled
        for (int i = 1; i <= 5; i++) begin
            drive(6'd62, 64'h4000 + 64'(8 * (i - 1)), 64'(i));
            chk($sformatf("std_ready_%0d", i), {63'd0, st_ready}, (i <= 4) ? 64'd1 : 64'd0);
            step();
        end
        st_valid = 1'b0;
        chk("std_full_count", {61'd0, count}, 64'd4);
        chk("std_full_ready", {63'd0, st_ready}, 64'd0);
        wait_valid("std_valid_timeout");
        step(); step();
        chk("std_stall_wdata", mem_wdata, 64'd1);
        chk("std_stall_addr", mem_addr, 64'h4000);
        chk("std_stall_be", {56'd0, mem_be}, 64'hFF);
        mem_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk($sformatf("std_order_valid_%0d", k), {63'd0, mem_valid}, 64'd1);
            chk($sformatf("std_order_data_%0d", k), mem_wdata, 64'(k));
            chk($sformatf("std_order_addr_%0d", k), mem_addr, 64'h4000 + 64'(8 * (k - 1)));
            step();
        end
        mem_ready = 1'b0;
        chk("std_drained_count", {61'd0, count}, 64'd0);
        chk("std_drained_valid", {63'd0, mem_valid}, 64'd0);

        // simultaneous push and pop at count 2
        drive(6'd62, 64'h5000, 64'h11); step();
        drive(6'd62, 64'h5008, 64'h22); step();
        st_valid = 1'b0;
        wait_valid("pp_valid_timeout");
        chk("pp_count_before", {61'd0, count}, 64'd2);
        drive(6'd62, 64'h5010, 64'h33);
        mem_ready = 1'b1;
        step();
        st_valid = 1'b0; mem_ready = 1'b0;
        chk("pp_count_same", {61'd0, count}, 64'd2);
        chk("pp_head", mem_wdata, 64'h22);
        drive(6'd62, 64'h5018, 64'h44); step();
        drive(6'd62, 64'h5020, 64'h55); step();
        chk("pp_full_count", {61'd0, count}, 64'd4);
        drive(6'd62, 64'h5028, 64'h66);
        mem_ready = 1'b1;
        chk("pp_full_ready", {63'd0, st_ready}, 64'd0);
        step();
        st_valid = 1'b0;
        chk("pp_full_pop_count", {61'd0, count}, 64'd3);
        chk("pp_drain_33", mem_wdata, 64'h33); step();
        chk("pp_drain_44", mem_wdata, 64'h44); step();
        chk("pp_drain_55", mem_wdata, 64'h55); step();
        mem_ready = 1'b0;
        chk("pp_drain_count", {61'd0, count}, 64'd0);

        // reset mid-drain with three entries
        drive(6'd62, 64'h6000, 64'hA); step();
        drive(6'd62, 64'h6008, 64'hB); step();
        drive(6'd62, 64'h6010, 64'hC); step();
        st_valid = 1'b0;
        wait_valid("rstmid_valid_timeout");
        chk("rstmid_count", {61'd0, count}, 64'd3);
        rst = 1'b1;
        mem_ready = 1'b1;
        step();
        chk("rstmid_mem_valid", {63'd0, mem_valid}, 64'd0);
        chk("rstmid_count_zero", {61'd0, count}, 64'd0);
        chk("rstmid_empty", {63'd0, empty}, 64'd1);
        rst = 1'b0;
        mem_ready = 1'b0;
        step();
        chk("rstmid_ready", {63'd0, st_ready}, 64'd1);
        chk("rstmid_still_empty", {63'd0, mem_valid}, 64'd0);

        // stw at offset 4 and load-overlap check
        drive(6'd36, 64'h3004, 64'hDEAD_BEEF_CAFE_F00D);
        step();
        st_valid = 1'b0;
        wait_valid("stw_valid_timeout");
        chk("stw_be", {56'd0, mem_be}, 64'hF0);
        chk("stw_wdata", mem_wdata, 64'hCAFE_F00D_0000_0000);
        ld_chk_addr = 64'h3000;
        #1;
        chk("hit_same_dw", {63'd0, ld_chk_hit}, {63'd0, FWD});
        ld_chk_addr = 64'h3008;
        #1;
        chk("hit_next_dw", {63'd0, ld_chk_hit}, 64'd0);
        mem_ready = 1'b1;
        step();
        mem_ready = 1'b0;
        ld_chk_addr = 64'h3000;
        #1;
        chk("hit_after_drain", {63'd0, ld_chk_hit}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
